// File: rtl/buzz_arbiter.sv
// Buzzer sound-effect arbiter: plays one of four tone channels over the background music.
// Optional build macro BUZZ_ARB_PREEMPT_EN lets a higher channel cut into a playing effect.
module buzz_arbiter #(
    parameter int SFX_LEN = 2500000,
    parameter int GAP_LEN = 250000,
    parameter int HALF_0  = 12500,
    parameter int HALF_1  = 20000,
    parameter int HALF_2  = 25000,
    parameter int HALF_3  = 50000
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic       bgm_in,
    input  logic [3:0] sfx_req,
    input  logic       mute,
    output logic       buzz,
    output logic [3:0] sfx_grant,
    output logic [3:0] sfx_ack,
    output logic       sfx_active
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [21:0] SFX_M1  = 22'(SFX_LEN - 1);
    localparam logic [21:0] GAP_M1  = 22'(GAP_LEN - 1);
    localparam logic [15:0] HALF0_M1 = 16'(HALF_0 - 1);
    localparam logic [15:0] HALF1_M1 = 16'(HALF_1 - 1);
    localparam logic [15:0] HALF2_M1 = 16'(HALF_2 - 1);
    localparam logic [15:0] HALF3_M1 = 16'(HALF_3 - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  ack_q, ack_d;
    logic [21:0] dur_q, dur_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        tone_q, tone_d;
    logic        buzz_q;
    logic [3:0]  pend_clr;
    logic [3:0]  hi_pick;
    logic [15:0] half_m1;
    logic        do_grant;

    function automatic logic [3:0] pick_hi(input logic [3:0] p);
        logic [3:0] r;
        r = 4'b0000;
        if (p[3])      r = 4'b1000;
        else if (p[2]) r = 4'b0100;
        else if (p[1]) r = 4'b0010;
        else if (p[0]) r = 4'b0001;
        return r;
    endfunction

    assign hi_pick = pick_hi(pending_q);

    always_comb begin
        half_m1 = HALF0_M1;
        case (grant_q)
            4'b0010: half_m1 = HALF1_M1;
            4'b0100: half_m1 = HALF2_M1;
            4'b1000: half_m1 = HALF3_M1;
            default: half_m1 = HALF0_M1;
        endcase
    end

    // Requests are fire-and-forget pulses: each one latches a pending bit, and
    // sfx_ack pulses for one cycle on the edge that channel is granted.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_d    = 4'b0000;
        dur_d    = dur_q;
        tcnt_d   = tcnt_q;
        tone_d   = tone_q;
        pend_clr = 4'b0000;
        do_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                do_grant = |pending_q;
            end
            ST_PLAY: begin
                if (tcnt_q == half_m1) begin
                    tcnt_d = 16'd0;
                    tone_d = ~tone_q;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
                if (dur_q == SFX_M1) begin
                    state_d = ST_GAP;
                    grant_d = 4'b0000;
                    dur_d   = 22'd0;
                    tcnt_d  = 16'd0;
                    tone_d  = 1'b0;
                end else begin
                    dur_d = dur_q + 22'd1;
                end
`ifdef BUZZ_ARB_PREEMPT_EN
                // One-hot codes order the same way as channel indices.
                do_grant = (hi_pick > grant_q);
`else
                do_grant = 1'b0;
`endif
            end
            ST_GAP: begin
                if (dur_q == GAP_M1) begin
                    state_d = ST_IDLE;
                    dur_d   = 22'd0;
                end else begin
                    dur_d = dur_q + 22'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (do_grant) begin
            state_d  = ST_PLAY;
            grant_d  = hi_pick;
            ack_d    = hi_pick;
            pend_clr = hi_pick;
            dur_d    = 22'd0;
            tcnt_d   = 16'd0;
            tone_d   = 1'b0;
        end
    end

    // A request landing on the grant edge survives the clear, so it replays.
    assign pending_d = (pending_q & ~pend_clr) | sfx_req;

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            grant_q   <= 4'b0000;
            ack_q     <= 4'b0000;
            dur_q     <= 22'd0;
            tcnt_q    <= 16'd0;
            tone_q    <= 1'b0;
            buzz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            dur_q     <= dur_d;
            tcnt_q    <= tcnt_d;
            tone_q    <= tone_d;
            buzz_q    <= mute ? 1'b0 : ((state_q == ST_PLAY) ? tone_q : bgm_in);
        end
    end

    assign buzz       = buzz_q;
    assign sfx_grant  = grant_q;
    assign sfx_ack    = ack_q;
    assign sfx_active = (state_q == ST_PLAY);

endmodule

// File: tb/tb_buzz_arbiter.sv
// Self-checking bench for buzz_arbiter with short effect timing (20-cycle effect, 4-cycle gap).
// Expected outputs are built from the timing rules and compared one vector per clock.
module tb_buzz_arbiter;

    localparam int SFX = 20;
    localparam int GAP = 4;

    logic       clk25 = 1'b0;
    logic       reset;
    logic       bgm_in;
    logic [3:0] sfx_req;
    logic       mute;
    logic       buzz;
    logic [3:0] sfx_grant;
    logic [3:0] sfx_ack;
    logic       sfx_active;

    int vectors     = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];

    always #5 clk25 = ~clk25;

    buzz_arbiter #(
        .SFX_LEN(SFX),
        .GAP_LEN(GAP),
        .HALF_0(2),
        .HALF_1(3),
        .HALF_2(4),
        .HALF_3(5)
    ) dut (
        .clk25(clk25),
        .reset(reset),
        .bgm_in(bgm_in),
        .sfx_req(sfx_req),
        .mute(mute),
        .buzz(buzz),
        .sfx_grant(sfx_grant),
        .sfx_ack(sfx_ack),
        .sfx_active(sfx_active)
    );

    // Vector layout: {buzz, sfx_active, sfx_grant[3:0], sfx_ack[3:0]}
    task automatic check_vec(input string tag, input logic [9:0] got, input logic [9:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int ch);
        return 4'(1 << ch);
    endfunction

    function automatic logic tone(input int ch, input int p);
        int h;
        h = (ch == 0) ? 2 : (ch == 1) ? 3 : (ch == 2) ? 4 : 5;
        return 1'((p / h) % 2);
    endfunction

    // Drive one cycle of inputs, clock, then compare against the oldest expectation.
    task automatic cycle(input string tag, input logic [3:0] req, input logic m,
                         input logic b, input logic rst);
        logic [9:0] e;
        sfx_req = req;
        mute    = m;
        bgm_in  = b;
        reset   = rst;
        @(posedge clk25);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'bx;
        check_vec(tag, {buzz, sfx_active, sfx_grant, sfx_ack}, e);
    endtask

    task automatic idle(input int n, input logic m, input logic [3:0] req0);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            exp_q.push_back({m ? 1'b0 : b, 1'b0, 4'b0000, 4'b0000});
            cycle($sformatf("idle%0d", i), (i == 0) ? req0 : 4'b0000, m, b, 1'b0);
        end
    endtask

    // pre < 0: cycle before the grant was not PLAY; otherwise it is the preempted tone.
    task automatic play(input int ch, input logic m, input int pre, input logic [3:0] req,
                        input logic [31:0] mask, input int len);
        logic b, eb;
        for (int p = 0; p < len; p++) begin
            b = 1'($urandom_range(0, 1));
            if (m) eb = 1'b0;
            else if (p == 0) eb = (pre < 0) ? b : 1'(pre);
            else eb = tone(ch, p - 1);
            exp_q.push_back({eb, 1'b1, oh(ch), (p == 0) ? oh(ch) : 4'b0000});
            cycle($sformatf("play ch%0d p%0d", ch, p), mask[p] ? req : 4'b0000, m, b, 1'b0);
        end
    endtask

    task automatic gap(input int ch, input logic m, input logic [3:0] req, input logic [31:0] mask);
        logic b, eb;
        for (int g = 0; g < GAP; g++) begin
            b  = 1'($urandom_range(0, 1));
            eb = m ? 1'b0 : ((g == 0) ? tone(ch, SFX - 1) : b);
            exp_q.push_back({eb, 1'b0, 4'b0000, 4'b0000});
            cycle($sformatf("gap ch%0d g%0d", ch, g), mask[g] ? req : 4'b0000, m, b, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(10'b0);
            cycle("reset", 4'b0000, 1'b0, 1'b1, 1'b1);
        end

        // Single effect on channel 0
        idle(1, 1'b0, 4'b0001);
        play(0, 1'b0, -1, 4'b0000, 32'd0, SFX);
        gap(0, 1'b0, 4'b0000, 32'd0);
        idle(2, 1'b0, 4'b0000);

        // Simultaneous requests: channel 2 wins, channel 1 follows
        idle(1, 1'b0, 4'b0110);
        play(2, 1'b0, -1, 4'b0000, 32'd0, SFX);
        gap(2, 1'b0, 4'b0000, 32'd0);
        idle(1, 1'b0, 4'b0000);
        play(1, 1'b0, -1, 4'b0000, 32'd0, SFX);
        gap(1, 1'b0, 4'b0000, 32'd0);
        idle(2, 1'b0, 4'b0000);

        // Higher request arriving during channel 0
        idle(1, 1'b0, 4'b0001);
`ifdef BUZZ_ARB_PREEMPT_EN
        play(0, 1'b0, -1, 4'b1000, 32'd1 << 5, 6);
        play(3, 1'b0, int'(tone(0, 5)), 4'b0000, 32'd0, SFX);
`else
        play(0, 1'b0, -1, 4'b1000, 32'd1 << 5, SFX);
        gap(0, 1'b0, 4'b0000, 32'd0);
        idle(1, 1'b0, 4'b0000);
        play(3, 1'b0, -1, 4'b0000, 32'd0, SFX);
`endif
        gap(3, 1'b0, 4'b0000, 32'd0);
        idle(2, 1'b0, 4'b0000);

        // Muted effect keeps sequencing
        idle(1, 1'b1, 4'b1000);
        play(3, 1'b1, -1, 4'b0000, 32'd0, SFX);
        gap(3, 1'b1, 4'b0000, 32'd0);
        idle(2, 1'b1, 4'b0000);
        idle(1, 1'b0, 4'b0000);

        // Reset mid-effect discards the pending channel 1
        idle(1, 1'b0, 4'b1000);
        play(3, 1'b0, -1, 4'b0010, 32'd1 << 3, 10);
        exp_q.push_back(10'b0);
        cycle("reset mid-play", 4'b0000, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        idle(6, 1'b0, 4'b0000);

        // Replay on same channel, merged gap requests, request on the grant edge
        idle(1, 1'b0, 4'b0001);
        play(0, 1'b0, -1, 4'b0001, 32'd1 << 3, SFX);
        gap(0, 1'b0, 4'b0010, 32'b1101);
        idle(1, 1'b0, 4'b0000);
        play(1, 1'b0, -1, 4'b0010, 32'd1, SFX);
        gap(1, 1'b0, 4'b0000, 32'd0);
        idle(1, 1'b0, 4'b0000);
        play(1, 1'b0, -1, 4'b0000, 32'd0, SFX);
        gap(1, 1'b0, 4'b0000, 32'd0);
        idle(1, 1'b0, 4'b0000);
        play(0, 1'b0, -1, 4'b0000, 32'd0, SFX);
        gap(0, 1'b0, 4'b0000, 32'd0);
        idle(3, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/buzz_arbiter.md
BUZZ_ARBITER -- requirements
Module: buzz_arbiter

Interface
REQ-001 SHALL have parameter SFX_LEN, default 2500000, meaning clk25 cycles per sound effect (100 ms).
REQ-002 SHALL have parameter GAP_LEN, default 250000, meaning silent-to-SFX gap cycles, during which BGM passes through.
REQ-003 SHALL have parameters HALF_0..HALF_3, defaults 12500/20000/25000/50000, meaning tone half-period in cycles for channel 0..3.
REQ-004 SHALL have port clk25, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port bgm_in, input, 1, background-music square wave from the BGM generator.
REQ-007 SHALL have port sfx_req, input, 4, one-cycle request pulses: [0] fire, [1] fly hit, [2] mosquito hit, [3] spider hit.
REQ-008 SHALL have port mute, input, 1; when high, buzz is forced low.
REQ-009 SHALL have port buzz, output, 1, registered buzzer drive.
REQ-010 SHALL have port sfx_grant, output, 4, one-hot channel currently playing; 0 when none.
REQ-011 SHALL have port sfx_ack, output, 4, one-cycle pulse on the channel granted.
REQ-012 SHALL have port sfx_active, output, 1, high in PLAY state.

Function
REQ-013 SHALL latch each sfx_req bit into a pending bit; repeat requests on an already-pending channel merge into one play.
REQ-014 SHALL implement states IDLE, PLAY and GAP.
REQ-015 IDLE: SHALL go to PLAY on the next edge when any pending bit is set, granting the highest pending index (3 highest).
REQ-016 On grant: SHALL clear that pending bit, pulse sfx_ack for exactly 1 cycle, set sfx_grant, and zero the duration and tone counters with tone low.
REQ-017 PLAY: tone SHALL toggle when the tone counter equals HALF_n-1, then the counter wraps to 0 (16-bit counter).
REQ-018 PLAY: SHALL end after exactly SFX_LEN cycles (22-bit counter), then go to GAP with sfx_grant=0.
REQ-019 GAP: SHALL last exactly GAP_LEN cycles, then go to IDLE. Pending requests are held and not granted during GAP.
REQ-020 buzz SHALL be registered with 1-cycle latency: 0 if mute, else the tone in PLAY, else bgm_in.
REQ-021 A request on the currently playing channel during PLAY SHALL set its pending bit and replay after GAP.
REQ-022 A request arriving in the same cycle its pending bit is cleared by grant SHALL leave the pending bit set (set wins).
REQ-023 mute SHALL NOT affect sequencing, counters or acks.

Reset
REQ-024 On reset high at a clock edge, SHALL clear pending, go to IDLE, and drive buzz=0, sfx_grant=0, sfx_ack=0, sfx_active=0, counters=0.
REQ-025 Reset during PLAY or GAP SHALL abort the effect with no ack and discard all pending requests.

Configuration
REQ-026 With macro BUZZ_ARB_PREEMPT_EN defined: in PLAY, a pending index higher than the playing one SHALL preempt on the next edge. It is granted per REQ-016, and the preempted effect is dropped (its pending bit stays clear).
REQ-027 Without BUZZ_ARB_PREEMPT_EN: each effect SHALL run to completion; there is no preemption logic.

Verification (SFX_LEN=20, GAP_LEN=4, HALF_0..3=2/3/4/5)
REQ-028 Single test: sfx_req=0001 at cycle 0 -> ack[0] at cycle 1; buzz toggles every 2 cycles for 20 cycles; then 4 cycles of bgm_in; sfx_active low.
REQ-029 Simultaneous test: sfx_req=0110 -> ch2 plays first (toggle every 4); after 20+4 cycles ch1 is granted (toggle every 3).
REQ-030 Preemption test: ch0 playing, req[3] at PLAY cycle 5. With PREEMPT_EN: ack[3] next cycle, ch0 never resumes. Without PREEMPT_EN: ch0 completes 20 cycles, then gap, then ch3.
REQ-031 Mute test: mute=1 throughout ch3 play -> buzz=0 every cycle; ack[3] and 20-cycle sfx_active unchanged.
REQ-032 Reset test: reset at PLAY cycle 10 with pending=0010 -> next cycle all outputs 0, IDLE; no later grant without a new request.
REQ-033 Merge test: req[1] pulsed 3 times while IDLE-blocked in GAP -> exactly one ack[1].
